// File: rtl/avmm_pkg.sv
// ============================================================================
// Module   : avmm_pkg
// Summary  : Shared types and constants for the Avalon-MM slave memory model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package avmm_pkg;

  localparam int LANE_W = 8;

  localparam logic [1:0] AVMM_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AVMM_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WWAIT = 2'd1,
    RWAIT = 2'd2
  } avmm_state_e;

  // Bits needed to hold the larger wait count, never narrower than one bit.
  function automatic int ctr_width(input int a, input int b);
    int m;
    int w;
    m = (a > b) ? a : b;
    w = $clog2(m + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/avmm_wait_ctr.sv
// ============================================================================
// Module   : avmm_wait_ctr
// Summary  : Loadable down-counter with enable and zero flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module avmm_wait_ctr #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/avalon_mm_slave_mem.sv
// ============================================================================
// Module   : avalon_mm_slave_mem
// Summary  : Avalon-MM slave memory with separate read/write wait states,
//            byte-lane write merge and out-of-range handling.
//            Optional macro AVMM_SLV_RESP_EN adds the response[1:0] port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module avalon_mm_slave_mem
  import avmm_pkg::*;
#(
  parameter int DW         = 32,
  parameter int N          = DW / 8,
  parameter int AW         = 32,
  parameter int MEM_SIZE   = 1024,
  parameter int WAIT_READ  = 4,
  parameter int WAIT_WRITE = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] address,
  input  logic          read,
  input  logic          write,
  input  logic          chipselect,
  input  logic [N-1:0]  byteenable,
  input  logic [DW-1:0] writedata,
  output logic [DW-1:0] readdata,
  output logic          waitrequest
`ifdef AVMM_SLV_RESP_EN
  ,output logic [1:0]   response
`endif
);

  localparam int CW = ctr_width(WAIT_READ, WAIT_WRITE);
  localparam int IW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

  localparam logic [CW-1:0] RD_LOAD   = CW'(WAIT_READ - 1);
  localparam logic [CW-1:0] WR_LOAD   = CW'((WAIT_WRITE == 0) ? 0 : WAIT_WRITE - 1);
  localparam logic [AW-1:0] MEM_LIMIT = AW'(MEM_SIZE);

  avmm_state_e   state_q;
  avmm_state_e   state_d;
  logic [DW-1:0] readdata_q;
  logic [DW-1:0] readdata_d;

  logic          req;
  logic          in_range;
  logic [IW-1:0] idx;
  logic [DW-1:0] key;
  logic [DW-1:0] cur_word;
  logic [DW-1:0] rd_word;
  logic [DW-1:0] wr_word;
  logic          done;
  logic          commit;
  logic          load_rd;

  logic          ctr_load;
  logic          ctr_en;
  logic [CW-1:0] ctr_val;
  logic [CW-1:0] cnt;
  logic          cnt_zero;

  // Storage holds Mem[i] ^ i, so the all-zero power-up image reads back as
  // Mem[i] = i without any load sequence; reset leaves contents alone.
  logic [DW-1:0] mem_q [MEM_SIZE] = '{default: '0};

  assign req      = chipselect & (read | write);
  assign in_range = (address < MEM_LIMIT);
  assign idx      = address[IW-1:0];
  assign key      = DW'(idx);
  assign cur_word = mem_q[idx] ^ key;
  assign rd_word  = in_range ? cur_word : '0;

  always_comb begin
    wr_word = cur_word;
    for (int i = 0; i < N; i++) begin
      if (byteenable[i]) begin
        wr_word[i*LANE_W +: LANE_W] = writedata[i*LANE_W +: LANE_W];
      end
    end
  end

  avmm_wait_ctr #(
    .W (CW)
  ) u_wait_ctr (
    .clk      (clk),
    .reset    (reset),
    .load     (ctr_load),
    .load_val (ctr_val),
    .en       (ctr_en),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d    = state_q;
    readdata_d = readdata_q;
    ctr_load   = 1'b0;
    ctr_val    = '0;
    ctr_en     = 1'b0;
    commit     = 1'b0;
    done       = 1'b0;
    load_rd    = 1'b0;

    case (state_q)
      IDLE: begin
        done = write && (WAIT_WRITE == 0);
        if (req && write) begin
          if (WAIT_WRITE == 0) begin
            commit = 1'b1;
          end else begin
            ctr_load = 1'b1;
            ctr_val  = WR_LOAD;
            state_d  = WWAIT;
          end
        end else if (req) begin
          ctr_load = 1'b1;
          ctr_val  = RD_LOAD;
          state_d  = RWAIT;
          load_rd  = (WAIT_READ == 1);
        end
      end

      WWAIT: begin
        done = cnt_zero;
        if (!(chipselect && write)) begin
          state_d = IDLE;
        end else if (cnt_zero) begin
          commit  = 1'b1;
          state_d = IDLE;
        end else begin
          ctr_en = 1'b1;
        end
      end

      RWAIT: begin
        done = cnt_zero;
        // A write showing up mid-read abandons the read; it restarts from IDLE.
        if (!(chipselect && read && !write)) begin
          state_d = IDLE;
        end else if (cnt_zero) begin
          state_d = IDLE;
        end else begin
          ctr_en  = 1'b1;
          load_rd = (cnt == CW'(1));
        end
      end

      default: state_d = IDLE;
    endcase

    if (load_rd) begin
      readdata_d = rd_word;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      readdata_q <= '0;
    end else begin
      state_q    <= state_d;
      readdata_q <= readdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (commit && in_range && !reset) begin
      mem_q[idx] <= wr_word ^ key;
    end
  end

  assign readdata    = readdata_q;
  assign waitrequest = req & ~done;

`ifdef AVMM_SLV_RESP_EN
  logic [1:0] resp_q;
  logic [1:0] resp_d;
  logic [1:0] range_resp;

  assign range_resp = in_range ? AVMM_RESP_OKAY : AVMM_RESP_SLVERR;

  always_comb begin
    resp_d = resp_q;
    if (load_rd) begin
      resp_d = range_resp;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_q <= AVMM_RESP_OKAY;
    end else begin
      resp_q <= resp_d;
    end
  end

  // Write status comes straight from the range check; reads report the
  // status captured together with readdata.
  assign response = (req && write) ? range_resp : resp_q;
`endif

endmodule

`default_nettype wire
